// File: rtl/scan_host_pkg.sv
// scan_host_pkg: shared state type, counter sizing helper and default chain lengths
// for the scan harness host driver.
package scan_host_pkg;

    localparam int DEFAULT_DIN_N  = 256;
    localparam int DEFAULT_DOUT_N = 256;

    typedef enum logic [1:0] {
        IDLE,
        SHIFT,
        STROBE,
        UNLOAD
    } state_t;

    // Wide enough to count a full phase of the longer chain without wrapping.
    function automatic int cnt_width(input int din_n, input int dout_n);
        int longest;
        longest = (din_n > dout_n) ? din_n : dout_n;
        return $clog2(longest + 1);
    endfunction

endpackage

// File: rtl/scan_shreg.sv
// scan_shreg: shift register with parallel load, serial in (LSB side),
// serial out (MSB) and parallel out. Load takes priority over shift.
module scan_shreg #(
    parameter int W = 8
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         load,
    input  logic [W-1:0] load_val,
    input  logic         shift_en,
    input  logic         ser_in,
    output logic         ser_out,
    output logic [W-1:0] par_out
);

    logic [W-1:0] q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            q <= '0;
        end else if (load) begin
            q <= load_val;
        end else if (shift_en) begin
            q <= {q[W-2:0], ser_in};
        end
    end

    assign ser_out = q[W-1];
    assign par_out = q;

endmodule

// File: rtl/scan_host.sv
// scan_host: serialises a stimulus vector into the scan harness, strobes it, and unloads
// the harness response. Optional loopback check enabled by SCAN_HOST_LOOPBACK_CHECK_EN.
module scan_host
    import scan_host_pkg::*;
#(
    parameter int DIN_N  = DEFAULT_DIN_N,
    parameter int DOUT_N = DEFAULT_DOUT_N
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              start,
    input  logic [DIN_N-1:0]  tx_data,
    output logic              busy,
    output logic              done,
    output logic [DOUT_N-1:0] rx_data,
    output logic              mismatch,
    output logic              di,
    output logic              stb,
    input  logic              dut_do
);

    localparam int CW = cnt_width(DIN_N, DOUT_N);
    localparam logic [CW-1:0] SHIFT_LAST  = CW'(DIN_N - 1);
    localparam logic [CW-1:0] UNLOAD_LAST = CW'(DOUT_N - 1);

    state_t            state;
    state_t            state_nx;
    logic [CW-1:0]     cnt;
    logic              accept;
    logic              tx_shift;
    logic              rx_shift;
    logic              cnt_clr;
    logic              finish;
    logic              rx_ser;
    logic [DIN_N-1:0]  tx_par;
    logic [DOUT_N-1:0] rx_par;
    logic [DOUT_N-1:0] rx_next;
    logic              unused_bits;

    // Zeros are shifted in behind the stimulus, so di falls to 0 on its own once the vector is out.
    scan_shreg #(.W(DIN_N)) u_tx (
        .clk      (clk),
        .rst_n    (rst_n),
        .load     (accept),
        .load_val (tx_data),
        .shift_en (tx_shift),
        .ser_in   (1'b0),
        .ser_out  (di),
        .par_out  (tx_par)
    );

    scan_shreg #(.W(DOUT_N)) u_rx (
        .clk      (clk),
        .rst_n    (rst_n),
        .load     (1'b0),
        .load_val ('0),
        .shift_en (rx_shift),
        .ser_in   (dut_do),
        .ser_out  (rx_ser),
        .par_out  (rx_par)
    );

    assign rx_next     = {rx_par[DOUT_N-2:0], dut_do};
    assign unused_bits = ^{tx_par, rx_ser, rx_par[DOUT_N-1]};

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= IDLE;
        end else begin
            state <= state_nx;
        end
    end

    always_comb begin
        state_nx = state;
        accept   = 1'b0;
        tx_shift = 1'b0;
        rx_shift = 1'b0;
        cnt_clr  = 1'b0;
        finish   = 1'b0;
        case (state)
            IDLE: begin
                if (start) begin
                    accept   = 1'b1;
                    cnt_clr  = 1'b1;
                    state_nx = SHIFT;
                end
            end
            SHIFT: begin
                tx_shift = 1'b1;
                if (cnt == SHIFT_LAST) begin
                    cnt_clr  = 1'b1;
                    state_nx = STROBE;
                end
            end
            STROBE: begin
                cnt_clr  = 1'b1;
                state_nx = UNLOAD;
            end
            UNLOAD: begin
                rx_shift = 1'b1;
                if (cnt == UNLOAD_LAST) begin
                    finish   = 1'b1;
                    state_nx = IDLE;
                end
            end
            default: state_nx = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt <= '0;
        end else if (cnt_clr) begin
            cnt <= '0;
        end else if (tx_shift || rx_shift) begin
            cnt <= cnt + 1'b1;
        end
    end

    // Outputs are decoded from the next state so they line up with the state they describe.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            stb     <= 1'b0;
            busy    <= 1'b0;
            done    <= 1'b0;
            rx_data <= '0;
        end else begin
            stb  <= (state_nx == STROBE);
            busy <= (state_nx != IDLE);
            done <= finish;
            if (finish) begin
                rx_data <= rx_next;
            end
        end
    end

`ifdef SCAN_HOST_LOOPBACK_CHECK_EN
    logic [DIN_N-1:0] cur_tx;
    logic [DIN_N-1:0] prev_tx;
    logic             prev_valid;
    logic             rx_differs;

    if (DIN_N == DOUT_N) begin : g_cmp
        assign rx_differs = (rx_next != prev_tx);
    end else begin : g_nocmp
        assign rx_differs = 1'b0;
    end

    // The response of this transaction belongs to the vector of the previous one.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cur_tx     <= '0;
            prev_tx    <= '0;
            prev_valid <= 1'b0;
            mismatch   <= 1'b0;
        end else begin
            if (accept) begin
                cur_tx <= tx_data;
            end
            if (finish) begin
                mismatch   <= prev_valid && rx_differs;
                prev_tx    <= cur_tx;
                prev_valid <= 1'b1;
            end
        end
    end
`else
    assign mismatch = 1'b0;
`endif

endmodule

// File: doc/scan_host.md
# scan_host

Host-side driver for the serial scan harness that wraps a region-of-interest under test. It serialises a parallel stimulus vector onto `di` MSB-first, pulses `stb` to load the harness's parallel input register, then clocks the harness's response back in from `dut_do` and presents it as a parallel word. It sits on the test-side of the harness, with the harness's `di`, `stb` and `do` pins on the opposite side, and runs in the same clock domain.

## Interface
- `DIN_N`, 256: stimulus vector width; equals the harness input chain length.
- `DOUT_N`, 256: response vector width; equals the harness output chain length.

- `clk`  in  1  sole clock; the harness uses the same clock.
- `rst_n`  in  1  asynchronous, active-low reset.
- `start`  in  1  request a transaction; sampled only when idle.
- `tx_data`  in  DIN_N  stimulus; latched on accepted `start`.
- `busy`  out  1  transaction in progress.
- `done`  out  1  one-cycle pulse; `rx_data` updated in the same cycle.
- `rx_data`  out  DOUT_N  captured response, with bit DOUT_N-1 being the first bit received.
- `mismatch`  out  1  loopback check result, valid with `done`; see Configuration.
- `di`  out  1  serial stimulus to the harness.
- `stb`  out  1  load/capture strobe to the harness.
- `dut_do`  in  1  serial response from the harness.

## Operation
- States: IDLE, SHIFT, STROBE, UNLOAD.
- IDLE, `start`=1:
  - latch `tx_data` into the tx shift register.
  - clear the counter and go to SHIFT.
- SHIFT lasts DIN_N cycles.
  - `di` = tx register MSB; the register shifts left by one each cycle.
  - Bit `tx_data[DIN_N-1]` goes out first.
  - After DIN_N cycles go to STROBE.
- STROBE lasts 1 cycle.
  - `stb`=1 and `di`=0.
  - On this edge the harness loads its parallel input from its chain and captures its current parallel output into its output chain.
- UNLOAD lasts DOUT_N cycles.
  - `di`=0.
  - Each edge samples `dut_do` into the rx shift register LSB and shifts left.
  - After DOUT_N samples, `rx_data` is updated and `done` pulses.
  - Then return to IDLE.
- Response semantics: the harness captures its output while it loads the new input. `rx_data` of transaction N is therefore the response to the vector loaded by transaction N-1, a one-transaction pipeline. Software issues a trailing dummy transaction to flush.
- `start` while busy is ignored and not queued.
- `start` in the `done` cycle is accepted, because the block is already in IDLE.
- `tx_data` changes after acceptance have no effect.
- Counter width is $clog2(max(DIN_N,DOUT_N)+1) bits and never wraps within a phase.
- `rst_n` low at any time, including mid-transaction:
  - state forced to IDLE immediately.
  - `di`, `stb`, `busy`, `done`, `mismatch` = 0 and `rx_data` = 0.
  - The harness chain contents are then undefined. The next transaction fully rewrites the DIN_N input chain.

## Timing
- `di` and `stb` are registered outputs, and `busy` is registered.
- The accepting edge is E0. The harness samples bit k (MSB first) at edge E(k+1), for k=0..DIN_N-1.
- `stb` is high between E(DIN_N) and E(DIN_N+1).
- Response bit i (MSB first) is sampled at E(DIN_N+2+i).
- `done` and the new `rx_data` appear after E(DIN_N+DOUT_N+1). Latency from E0 to `done` is DIN_N+DOUT_N+1 cycles.
- `busy` is high from after E0 until after the final sample edge, and is low in the `done` cycle.
- Back-to-back throughput is one transaction per DIN_N+DOUT_N+1 cycles.

## Configuration
- `SCAN_HOST_LOOPBACK_CHECK_EN` defined:
  - the block holds the previously accepted `tx_data` (prev_tx) plus a valid flag.
  - At `done`, `mismatch` = (rx_data != prev_tx) when DIN_N==DOUT_N and the flag is set; otherwise 0.
  - The flag clears on reset, so the first transaction never flags.
  - `mismatch` holds its value until the next `done`.
- Macro undefined: no prev_tx storage and `mismatch` tied to 0.

## Structure
- `scan_host_pkg` holds the state enum, the counter-width function, and the default DIN_N/DOUT_N constants.
- Sub-module `scan_shreg` is a parameterised shift register with parallel load, serial in, serial out and parallel out. It is instantiated twice, once for tx and once for rx.
- FSM, counter and loopback check live in `scan_host`.

## Test plan
All tests use DIN_N=DOUT_N=8 with a behavioural harness whose region under test is a passthrough.

- Reset: hold `rst_n` low, then release -> `di`, `stb`, `busy`, `done`, `mismatch` = 0 and `rx_data` = 0x00.
- Waveform: start with 0xA5 -> `di` sequence 1,0,1,0,0,1,0,1 on E1..E8; `stb` high for the single cycle before E9; `done` after E17.
- Pipeline: transactions 0xA5, 0x3C, 0x00 -> `rx_data` = 0x00, 0xA5, 0x3C.
- Busy: assert `start` with 0xFF during SHIFT -> ignored. A later `start` issued in the `done` cycle is accepted with no idle gap.
- Mid-transaction reset: drop `rst_n` at E4 -> all outputs 0 asynchronously. The next transaction 0x5A followed by a dummy returns `rx_data`=0x5A.
- With `SCAN_HOST_LOOPBACK_CHECK_EN` and a harness that inverts bit 0: transactions 0x10, 0x20 -> `mismatch`=0 at the first `done`, then 1 at the second (rx 0x11 != 0x10).
